// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch slice: widths, reset values
// and the FIFO entry layout.
package inst_fetch_pkg;

    localparam logic        RESET     = 1'b1;
    localparam int unsigned INST_W    = 32;
    localparam int unsigned PC_W      = 16;
    localparam int unsigned IFQ_DEPTH = 4;
    localparam logic [15:0] RESET_PC  = 16'h0000;
    localparam int unsigned PTR_W     = $clog2(IFQ_DEPTH);
    localparam int unsigned CNT_W     = $clog2(IFQ_DEPTH + 1);

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } ifq_entry_t;

    // Buffered plus in-flight must leave room for the request being issued.
    function automatic logic can_issue(input logic [CNT_W-1:0] count,
                                       input logic             inflight);
        return (count + CNT_W'(inflight)) <= CNT_W'(IFQ_DEPTH - 1);
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus bundle: redirect input, instruction-memory port and the
// instruction output handshake.
interface inst_fetch_if;
    import inst_fetch_pkg::*;

    logic              jump_i;
    logic [PC_W-1:0]   jump_addr_i;
    logic              imem_req_o;
    logic [PC_W-1:0]   imem_addr_o;
    logic [INST_W-1:0] imem_data_i;
    logic              inst_ready_i;
    logic              inst_valid_o;
    logic [INST_W-1:0] inst_o;
    logic [PC_W-1:0]   inst_pc_o;

    modport master (
        input  jump_i, jump_addr_i, imem_data_i, inst_ready_i,
        output imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o
    );

    modport slave (
        output jump_i, jump_addr_i, imem_data_i, inst_ready_i,
        input  imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o
    );

endinterface

// File: rtl/inst_fifo.sv
// Four-entry synchronous queue of {pc, inst}; flush beats push and pop.
module inst_fifo
    import inst_fetch_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  ifq_entry_t       push_data_i,
    output ifq_entry_t       head_o,
    output logic [CNT_W-1:0] count_o
);

    ifq_entry_t       mem_q [IFQ_DEPTH];
    ifq_entry_t       mem_d [IFQ_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
        if (rst_i == RESET) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        head_o  = mem_q[rd_ptr_q];
        count_o = count_q;
    end

    // Issue throttling keeps a push onto a full queue impossible.
    assert property (@(posedge clk_i) disable iff (rst_i == RESET)
        !(push_i && !pop_i && !flush_i && count_q == CNT_W'(IFQ_DEPTH)));

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, one-deep outstanding memory read and a small
// prefetch queue feeding the decoder.
module inst_fetch
    import inst_fetch_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    inst_fetch_if.master bus
);

    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  tag_q, tag_d;
    logic             inflight_q, inflight_d;
    logic             in_reset;
    logic             issue;
    logic             push;
    logic             pop;
    logic             valid;
    logic [CNT_W-1:0] count;
    ifq_entry_t       head;
    ifq_entry_t       push_entry;

    // A response landing in a jump or reset cycle is dropped; nothing is
    // left in flight afterwards, so no separate kill flag is needed.
    always_comb begin
        in_reset   = (rst_i == RESET);
        issue      = !in_reset && !bus.jump_i && can_issue(count, inflight_q);
        push       = !in_reset && !bus.jump_i && inflight_q;
        valid      = !in_reset && (count != '0);
        pop        = valid && bus.inst_ready_i && !bus.jump_i;
        push_entry = '{pc: tag_q, inst: bus.imem_data_i};
    end

    always_comb begin
        pc_d       = pc_q;
        tag_d      = tag_q;
        inflight_d = issue;
        if (in_reset) begin
            pc_d = RESET_PC;
        end else if (bus.jump_i) begin
            pc_d = bus.jump_addr_i;
        end else if (issue) begin
            pc_d  = pc_q + 1'b1;
            tag_d = pc_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i == RESET) begin
            pc_q       <= RESET_PC;
            tag_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
        end
    end

    inst_fifo u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (bus.jump_i),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (push_entry),
        .head_o      (head),
        .count_o     (count)
    );

    always_comb begin
        bus.imem_req_o   = issue;
        bus.imem_addr_o  = in_reset ? '0 : pc_q;
        bus.inst_valid_o = valid;
        bus.inst_o       = valid ? head.inst : '0;
        bus.inst_pc_o    = valid ? head.pc : '0;
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed and randomized bench for inst_fetch, checked against a
// transaction-level model of issued-but-unconsumed fetches.
module tb_inst_fetch;

    typedef struct {
        logic [15:0] pc;
        int unsigned cyc;
    } txn_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [15:0]  mem_addr_q = '0;
    inst_fetch_if bus ();

    txn_t         q[$];
    logic [15:0]  model_pc = 16'h0000;
    int unsigned  cyc = 0;
    int           n_checks = 0;
    int           n_fail = 0;
    int           n_issue_obs = 0;

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {16'h0000, a} ^ 32'hA5A5A5A5;
    endfunction

    always @(posedge clk) mem_addr_q <= bus.imem_addr_o;
    assign bus.imem_data_i = mem_word(mem_addr_q);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input logic r, input logic j, input logic [15:0] ja, input logic rdy);
        logic        exp_req;
        logic        exp_valid;
        logic [15:0] exp_pc;
        rst              = r;
        bus.jump_i       = j;
        bus.jump_addr_i  = ja;
        bus.inst_ready_i = rdy;
        @(negedge clk);
        exp_req   = !r && !j && (q.size() <= 3);
        exp_valid = !r && (q.size() != 0) && ((cyc - q[0].cyc) >= 2);
        exp_pc    = exp_valid ? q[0].pc : 16'h0000;
        if (bus.imem_req_o === 1'b1) n_issue_obs++;
        chk("imem_req", 32'(bus.imem_req_o), 32'(exp_req));
        chk("imem_addr", 32'(bus.imem_addr_o), 32'(r ? 16'h0000 : model_pc));
        chk("inst_valid", 32'(bus.inst_valid_o), 32'(exp_valid));
        if (exp_valid || r) begin
            chk("inst_pc", 32'(bus.inst_pc_o), 32'(exp_pc));
            chk("inst", bus.inst_o, exp_valid ? mem_word(exp_pc) : 32'h0);
        end
        if (r) begin
            q.delete();
            model_pc = 16'h0000;
        end else if (j) begin
            q.delete();
            model_pc = ja;
        end else begin
            if (exp_valid && rdy) void'(q.pop_front());
            if (exp_req) begin
                q.push_back('{pc: model_pc, cyc: cyc});
                model_pc = model_pc + 16'h0001;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, rdy);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0000, 1'b0);
    endtask

    initial begin
        logic found;
        logic [15:0] ja;

        bus.jump_i       = 1'b0;
        bus.jump_addr_i  = '0;
        bus.inst_ready_i = 1'b0;

        // Free-running stream from reset.
        do_reset(3);
        run(20, 1'b1);

        // Stalled decoder from reset: four issues, then release.
        do_reset(2);
        n_issue_obs = 0;
        run(10, 1'b0);
        chk("stall_issue_count", 32'(n_issue_obs), 32'd4);
        run(12, 1'b1);

        // Jump while the fetch of 0x0005 is in flight.
        do_reset(2);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b0, 1'b0, 16'h0000, 1'b0 == 1'b1 ? 1'b0 : 1'b1);
            if (model_pc == 16'h0006) found = 1'b1;
        end
        chk("reach_fetch_5", 32'(found), 32'd1);
        step(1'b0, 1'b1, 16'h0100, 1'b1);
        run(10, 1'b1);

        // Jump with pop in the same cycle while the queue is full.
        do_reset(2);
        run(8, 1'b0);
        step(1'b0, 1'b1, 16'h1234, 1'b1);
        run(8, 1'b1);

        // PC wrap.
        step(1'b0, 1'b1, 16'hFFFE, 1'b1);
        run(10, 1'b1);

        // One-cycle reset pulse mid-stream.
        run(6, 1'b1);
        do_reset(1);
        run(8, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            ja = ($urandom_range(0, 1) == 0) ? 16'($urandom)
                                             : 16'hFFFC + 16'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0)
                step(1'b1, 1'b0, 16'h0000, 1'b0);
            else
                step(1'b0, $urandom_range(0, 19) == 0, ja, $urandom_range(0, 3) != 0);
        end
        run(10, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
